// File: rtl/id_ex_pkg.sv
// Shared instruction constants for the decode/execute boundary.
package id_ex_pkg;

  // Canonical RV32I NOP: addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: instruction, address and two operands, with load and clear-to-NOP.
module pipe_entry #(
  parameter int unsigned DW      = 32,
  parameter logic [DW-1:0] NOP_INS = '0
) (
  input  logic          clk,
  input  logic          load,
  input  logic          clr,
  input  logic [DW-1:0] ins_d,
  input  logic [DW-1:0] addr_d,
  input  logic [DW-1:0] rs1_d,
  input  logic [DW-1:0] rs2_d,
  output logic [DW-1:0] ins_q,
  output logic [DW-1:0] addr_q,
  output logic [DW-1:0] rs1_q,
  output logic [DW-1:0] rs2_q
);

  // Clear wins over load so a flush never exposes a half-written slot.
  always_ff @(posedge clk) begin
    if (clr) begin
      ins_q  <= NOP_INS;
      addr_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else if (load) begin
      ins_q  <= ins_d;
      addr_q <= addr_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
    end
  end

endmodule

// File: rtl/id_ex.sv
// Decode-to-execute pipeline register with a one-entry skid buffer and synchronous flush.
module id_ex
  import id_ex_pkg::*;
#(
  parameter int unsigned   DW      = 32,
  parameter logic [DW-1:0] NOP_INS = DW'(INST_NOP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] ins_i,
  input  logic [DW-1:0] ins_addr_i,
  input  logic [DW-1:0] rs1_data_i,
  input  logic [DW-1:0] rs2_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          flush_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [DW-1:0] ins_o,
  output logic [DW-1:0] ins_addr_o,
  output logic [DW-1:0] rs1_data_o,
  output logic [DW-1:0] rs2_data_o
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StFull  = 2'd1;
  localparam logic [1:0] StSkid  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       accept, consume;
  logic       main_load, main_clr, main_from_skid;
  logic       skid_load, skid_clr;

  logic [DW-1:0] skid_ins, skid_addr, skid_rs1, skid_rs2;
  logic [DW-1:0] main_ins_d, main_addr_d, main_rs1_d, main_rs2_d;

  // Ready is a pure state decode so there is no path from out_ready_i.
  assign in_ready_o  = (state_q != StSkid);
  assign out_valid_o = (state_q == StFull) || (state_q == StSkid);
  assign accept      = in_valid_i && in_ready_o;
  assign consume     = out_valid_o && out_ready_i;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (!rst_n || flush_i) begin
      state_d  = StEmpty;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StFull;
            main_load = 1'b1;
          end
        end
        StFull: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = StSkid;
            skid_load = 1'b1;
          end else if (consume) begin
            state_d  = StEmpty;
            main_clr = 1'b1;
          end
        end
        StSkid: begin
          if (consume) begin
            state_d        = StFull;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = StEmpty;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    main_ins_d  = ins_i;
    main_addr_d = ins_addr_i;
    main_rs1_d  = rs1_data_i;
    main_rs2_d  = rs2_data_i;
    if (main_from_skid) begin
      main_ins_d  = skid_ins;
      main_addr_d = skid_addr;
      main_rs1_d  = skid_rs1;
      main_rs2_d  = skid_rs2;
    end
  end

  pipe_entry #(
    .DW      (DW),
    .NOP_INS (NOP_INS)
  ) u_main (
    .clk    (clk),
    .load   (main_load),
    .clr    (main_clr),
    .ins_d  (main_ins_d),
    .addr_d (main_addr_d),
    .rs1_d  (main_rs1_d),
    .rs2_d  (main_rs2_d),
    .ins_q  (ins_o),
    .addr_q (ins_addr_o),
    .rs1_q  (rs1_data_o),
    .rs2_q  (rs2_data_o)
  );

  pipe_entry #(
    .DW      (DW),
    .NOP_INS (NOP_INS)
  ) u_skid (
    .clk    (clk),
    .load   (skid_load),
    .clr    (skid_clr),
    .ins_d  (ins_i),
    .addr_d (ins_addr_i),
    .rs1_d  (rs1_data_i),
    .rs2_d  (rs2_data_i),
    .ins_q  (skid_ins),
    .addr_q (skid_addr),
    .rs1_q  (skid_rs1),
    .rs2_q  (skid_rs2)
  );

endmodule

// File: doc/id_ex.md
Name: id_ex

Overview:
- Pipeline register between the decode stage and the execute stage.
- Captures instruction, instruction address and both source-operand values from decode, and presents them to execute one cycle later.
- Supports stall via a valid/ready handshake with a one-entry skid buffer, and a synchronous flush for branch/jump redirect.
- Whenever no valid instruction is held, drives a canonical NOP so execute's combinational logic is harmless.

Parameters:
- DW, 32, data/address width of instruction, address and operand paths
- NOP_INS, 32'h0000_0013, instruction word driven when empty (addi x0,x0,0)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- ins_i  input  DW  instruction from decode
- ins_addr_i  input  DW  instruction address from decode
- rs1_data_i  input  DW  rs1 operand value from register file read
- rs2_data_i  input  DW  rs2 operand value from register file read
- in_valid_i  input  1  decode presents a valid instruction
- in_ready_o  output  1  block can accept an instruction this cycle
- flush_i  input  1  discard all held and incoming instructions
- out_ready_i  input  1  execute consumes the presented instruction this cycle
- out_valid_o  output  1  presented instruction is valid
- ins_o  output  DW  instruction to execute
- ins_addr_o  output  DW  instruction address to execute
- rs1_data_o  output  DW  rs1 operand to execute
- rs2_data_o  output  DW  rs2 operand to execute

Behaviour:
- Storage: main entry (drives outputs) plus skid entry. Each entry holds ins, addr, rs1, rs2 and a valid bit.
- States: EMPTY (neither valid), FULL (main valid), SKID (main and skid valid).
- Accept = in_valid_i & in_ready_o. Consume = out_valid_o & out_ready_i.
- in_ready_o = !skid_valid. It is a registered state decode only, with no combinational path from out_ready_i.
- EMPTY:
  - accept -> FULL, main loaded.
  - otherwise stay EMPTY.
- FULL:
  - accept and consume -> FULL, main reloaded with new data.
  - accept only -> SKID, new data goes to skid.
  - consume only -> EMPTY.
  - neither -> hold.
- SKID:
  - consume -> FULL, skid moves to main, skid cleared.
  - otherwise hold.
  - in_ready_o=0, so no accept is possible.
- Latency: instruction accepted in cycle N appears on outputs in N+1. Sustained throughput is 1 per cycle while out_ready_i=1.
- Outputs when main invalid: ins_o=NOP_INS, ins_addr_o=0, rs1_data_o=0, rs2_data_o=0, out_valid_o=0.
- Held data stays bit-stable while out_valid_o=1 and out_ready_i=0.
- flush_i=1 at a clock edge:
  - both entries invalidated, state -> EMPTY.
  - any simultaneous accept is dropped.
  - takes priority over every transition.
- rst_n=0 at a clock edge: same effect as flush (state EMPTY, outputs at NOP values, in_ready_o=1 after reset). Reset has priority over flush.
- Reset or flush mid-stall: the held instruction is lost. No partial update of the data fields is visible.
- Operand widths pass through unchanged. No sign-extension or arithmetic is performed here.

Decomposition:
- Add `INST_NOP` (32'h0000_0013) to the shared instruction defines file. NOP_INS defaults to it.
- State encoding (EMPTY/FULL/SKID) is local to the block as localparams. It is not shared.
- One natural sub-module: pipe_entry, a DW-wide 4-field register with load enable and synchronous clear-to-NOP. Instantiate it twice (main, skid).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> ins_o=32'h0000_0013, out_valid_o=0, in_ready_o=1, all data outputs 0.
- Streaming: feed 4 instructions (ins 32'h00500093, addr 0,4,8,12), in_valid_i=1, out_ready_i=1 -> each appears exactly 1 cycle later in order, out_valid_o=1 for 4 consecutive cycles.
- Stall:
  - Setup: out_ready_i=0 while sending A (addr 0x10), then B (addr 0x14).
  - Check: A is held on outputs, B goes to skid, in_ready_o=0.
  - Release: raise out_ready_i -> A then B consumed on consecutive cycles, in_ready_o returns to 1.
- Flush in SKID:
  - Setup: state SKID with A/B held.
  - Stimulus: pulse flush_i for one cycle with in_valid_i=1, C presented.
  - Check: next cycle out_valid_o=0, ins_o=NOP, C not captured.
- Flush/reset priority: assert flush_i and rst_n=0 together during FULL -> EMPTY. Then release both and send D with rs1=32'hDEAD_BEEF -> D appears with rs1_data_o=32'hDEAD_BEEF.
- Data stability: random out_ready_i toggling over 200 instructions -> scoreboard shows no loss, duplication or reorder, and held outputs do not change while stalled.
